// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: decoder widths and the one-hot decode helper.
// Pure declarations; no latency or backpressure of its own.
package cpu_pkg;

  localparam int DEC_IN_W      = 2;
  localparam int DEC_MAX_IN_W  = 4;
  localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_IN_W;

  // Decodes into the widest legal vector; callers keep the low 2**IN_W bits.
  function automatic logic [DEC_MAX_OUT_W-1:0] onehot_dec(
    input logic                    en,
    input logic [DEC_MAX_IN_W-1:0] sel
  );
    logic [DEC_MAX_OUT_W-1:0] v;
    v = '0;
    if (en) v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_2to4_dec_core.sv
// Combinational enable-gated one-hot decoder (E, A -> next_y).
// Zero latency, no backpressure.
module dec_core
  import cpu_pkg::*;
#(
  parameter int IN_W  = DEC_IN_W,
  parameter int OUT_W = 1 << IN_W
) (
  input  logic             E,
  input  logic [IN_W-1:0]  A,
  output logic [OUT_W-1:0] next_y
);

  logic [DEC_MAX_OUT_W-1:0] full_dec;
  logic                     unused_hi;

  assign full_dec  = onehot_dec(E, DEC_MAX_IN_W'(A));
  // A < OUT_W always, so bits above OUT_W-1 are never set.
  assign next_y    = full_dec[OUT_W-1:0];
  assign unused_hi = ^full_dec;

endmodule

// File: rtl/decoder_2to4.sv
// One-hot decoder with enable; Y registered (1 cycle) when REG_OUT=1, combinational otherwise.
// No handshake or backpressure: a new E/A is accepted every cycle.
module decoder_2to4
  import cpu_pkg::*;
#(
  parameter int IN_W    = DEC_IN_W,
  parameter int REG_OUT = 1,
  localparam int OUT_W  = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E,
  input  logic [IN_W-1:0]  A,
  output logic [OUT_W-1:0] Y
);

  logic [OUT_W-1:0] y_d;

  dec_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_dec_core (
    .E      (E),
    .A      (A),
    .next_y (y_d)
  );

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [OUT_W-1:0] y_q;

      // Async clear keeps the strobe low from the moment reset asserts.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= '0;
        else        y_q <= y_d;
      end

      assign Y = y_q;
    end else begin : g_comb
      assign Y = rst_n ? y_d : '0;
    end
  endgenerate

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert ($onehot0(Y));
  end
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// Bench for decoder_2to4: registered and combinational builds side by side,
// registered output checked against a queue of expected strobes.
module tb_decoder_2to4;

  logic       clk;
  logic       rst_n;
  logic       E;
  logic [1:0] A;
  logic [3:0] y_r;
  logic [3:0] y_c;

  logic [3:0] exp_q[$];
  logic [3:0] prev_exp;
  int         n_checks;
  int         n_fail;

  decoder_2to4 #(.IN_W(2), .REG_OUT(1)) dut_r (
    .clk   (clk),
    .rst_n (rst_n),
    .E     (E),
    .A     (A),
    .Y     (y_r)
  );

  decoder_2to4 #(.IN_W(2), .REG_OUT(0)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .E     (E),
    .A     (A),
    .Y     (y_c)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [3:0] model(input logic r, input logic e, input logic [1:0] a);
    logic [3:0] v;
    v = 4'b0000;
    case (a)
      2'd0: v = 4'b0001;
      2'd1: v = 4'b0010;
      2'd2: v = 4'b0100;
      default: v = 4'b1000;
    endcase
    return (r && e) ? v : 4'b0000;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, got, want, $time);
    end
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic step(input logic e, input logic [1:0] a);
    logic [3:0] want;
    E = e;
    A = a;
    exp_q.push_back(model(rst_n, e, a));
    #1;
    check("comb_same_delta", y_c, model(rst_n, e, a));
    check("reg_holds_before_edge", y_r, prev_exp);
    @(negedge clk);
    want = exp_q.pop_front();
    check("reg_after_edge", y_r, want);
    prev_exp = want;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    prev_exp = 4'b0000;
    rst_n    = 1'b1;
    E        = 1'b0;
    A        = 2'd0;

    // Reset asserted with an active select: outputs must be zero at once.
    #1;
    rst_n = 1'b0;
    E     = 1'b1;
    A     = 2'd3;
    #1;
    check("reset_imm_reg", y_r, 4'b0000);
    check("reset_imm_comb", y_c, 4'b0000);
    @(negedge clk);
    step(1'b1, 2'd3);
    step(1'b1, 2'd3);

    // Release reset with enable low.
    rst_n = 1'b1;
    step(1'b0, 2'd0);

    // Select sweep with enable high.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i));

    // Asynchronous reset between edges, then recovery.
    step(1'b1, 2'd2);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_reset_reg", y_r, 4'b0000);
    check("async_reset_comb", y_c, 4'b0000);
    prev_exp = 4'b0000;
    @(negedge clk);
    check("reset_held_reg", y_r, 4'b0000);
    step(1'b1, 2'd2);
    rst_n = 1'b1;
    step(1'b1, 2'd2);

    // Enable toggle with select held.
    step(1'b1, 2'd1);
    step(1'b0, 2'd1);
    step(1'b1, 2'd1);

    // Random enable/select traffic.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
